mem_arbiter2: RTL and testbench

Two-port round-robin arbiter that shares one single-port, 32-bit-wide synchronous SRAM between two requesters, each using the native valid/ready CPU memory interface. It sits between the CPU core (port 0) and a second master such as a loader or DMA engine (port 1), and owns the SRAM enable, byte strobes and address. An optional console decode diverts byte writes at 0x1000_0000 to a character output instead of memory.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 29 ++
 rtl/mem_arbiter2.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter2.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types and constants for the two-port SRAM arbiter:
//   - state_t    : arbiter FSM states (IDLE / ACCESS / RESP)
//   - gnt_idx_t  : index of the granted requester port (0 or 1)
//   - CONSOLE_ADDR : byte address of the console output register
//                    (decoded only when MEMARB_CONSOLE_EN is defined)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic gnt_idx_t;

  localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Combinational two-request round-robin pick. The caller keeps the
//   last_grant register; this block only decides who wins this cycle.
// Ports:
//   req0, req1  in   request bits of port 0 / port 1
//   last_grant  in   port that won the previous grant
//   gnt         out  winning port index (meaningful when gnt_vld)
//   gnt_vld     out  at least one request present
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  gnt_idx_t last_grant,
  output gnt_idx_t gnt,
  output logic     gnt_vld
);

  always_comb begin
    gnt_vld = req0 | req1;
    if (req0 && req1) begin
      // Tie: the port that did not win last time goes now.
      gnt = ~last_grant;
    end else begin
      gnt = req1 ? 1'b1 : 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter2.sv
// mem_arbiter2
//   Round-robin arbiter sharing one single-port 32-bit synchronous SRAM
//   between two valid/ready memory masters (port 0 = CPU, port 1 = DMA or
//   loader). One transaction takes three cycles: IDLE (grant and latch),
//   ACCESS (drive SRAM), RESP (ready pulse with read data).
//   Optional feature macro: MEMARB_CONSOLE_EN -- byte writes to
//   0x1000_0000 are diverted to console_valid / console_data.
// Ports:
//   clk, resetn                   clock, asynchronous active-low reset
//   m0_* / m1_*                   requester ports (valid, instr, addr,
//                                 wdata, wstrb in; ready, rdata out)
//   sram_en/we/addr/wdata         SRAM control and write path
//   sram_rdata                    SRAM read data, one cycle after sram_en
//   console_valid, console_data   console byte output (tied 0 when the
//                                 console feature is not built)
module mem_arbiter2
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          m0_valid,
  input  logic          m0_instr,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic          m0_ready,
  output logic [31:0]   m0_rdata,
  input  logic          m1_valid,
  input  logic          m1_instr,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic          m1_ready,
  output logic [31:0]   m1_rdata,
  output logic          sram_en,
  output logic [3:0]    sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata,
  output logic          console_valid,
  output logic [7:0]    console_data
);

  state_t      state, state_nxt;
  gnt_idx_t    last_grant, gnt_pick, gnt_q;
  logic        gnt_vld;
  logic        take;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        in_range;
  logic        is_console;
  logic        sram_hit;
  logic [31:0] resp_rdata;

  // Instruction flags are trace-only and byte-offset bits never reach the
  // word-addressed SRAM.
  logic unused_inputs;
  assign unused_inputs = ^{m0_instr, m1_instr, m0_addr[1:0], m1_addr[1:0]};

  rr_arbiter2 u_rr (
    .req0       (m0_valid),
    .req1       (m1_valid),
    .last_grant (last_grant),
    .gnt        (gnt_pick),
    .gnt_vld    (gnt_vld)
  );

  assign take = (state == IDLE) && gnt_vld;

  // Control state: the only registers that need reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        last_grant <= gnt_pick;
        gnt_q      <= gnt_pick;
      end
    end
  end

  // Request payload capture in IDLE; every output using it is gated by state.
  always_ff @(posedge clk) begin
    if (take) begin
      addr_q  <= gnt_pick ? m1_addr[31:2] : m0_addr[31:2];
      wdata_q <= gnt_pick ? m1_wdata      : m0_wdata;
      wstrb_q <= gnt_pick ? m1_wstrb      : m0_wstrb;
    end
  end

  assign in_range = (addr_q[31:AW+2] == '0);

`ifdef MEMARB_CONSOLE_EN
  assign is_console    = ({addr_q, 2'b00} == CONSOLE_ADDR);
  assign console_valid = (state == RESP) && is_console && wstrb_q[0];
  assign console_data  = console_valid ? wdata_q[7:0] : 8'h00;
`else
  assign is_console    = 1'b0;
  assign console_valid = 1'b0;
  assign console_data  = 8'h00;
`endif

  // Console address wins over the SRAM window should they ever overlap.
  assign sram_hit = in_range && !is_console;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 4'b0000;
    sram_addr  = '0;
    sram_wdata = '0;
    m0_ready   = 1'b0;
    m1_ready   = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    resp_rdata = '0;

    if ((state == ACCESS) && sram_hit) begin
      sram_en    = 1'b1;
      sram_we    = wstrb_q;
      sram_addr  = addr_q[AW+1:2];
      sram_wdata = wdata_q;
    end

    if (state == RESP) begin
      // Only an in-range read returns SRAM data; writes, console and
      // out-of-range accesses complete with zero.
      if (sram_hit && (wstrb_q == 4'b0000)) begin
        resp_rdata = sram_rdata;
      end
      if (gnt_q) begin
        m1_ready = 1'b1;
        m1_rdata = resp_rdata;
      end else begin
        m0_ready = 1'b1;
        m0_rdata = resp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
`timescale 1ns/1ps
module tb_mem_arbiter2;

  localparam int AW = 16;
`ifdef MEMARB_CONSOLE_EN
  localparam bit CON_EN = 1'b1;
`else
  localparam bit CON_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          m0_valid = 1'b0, m1_valid = 1'b0;
  logic          m0_instr = 1'b0, m1_instr = 1'b0;
  logic [31:0]   m0_addr = '0, m1_addr = '0;
  logic [31:0]   m0_wdata = '0, m1_wdata = '0;
  logic [3:0]    m0_wstrb = '0, m1_wstrb = '0;
  logic          m0_ready, m1_ready;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          sram_en;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = '0;
  logic          console_valid;
  logic [7:0]    console_data;

  always #5 clk = ~clk;

  mem_arbiter2 #(.AW(AW)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .console_valid(console_valid), .console_data(console_data)
  );

  // SRAM: registered read, byte-masked write.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_en) begin
      sram_rdata <= mem[sram_addr];
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  // Reference memory and scoreboard.
  logic [31:0] ref_mem [0:(1<<AW)-1];
  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        cv;
    logic [7:0]  cd;
  } exp_t;
  exp_t sb[$];
  int   rdy_cyc[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_con(input logic [31:0] a);
    return CON_EN && (a[31:2] == 30'h0400_0000);
  endfunction

  function automatic bit is_hit(input logic [31:0] a);
    return (a[31:AW+2] == '0) && !is_con(a);
  endfunction

  task automatic predict(input int p, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws);
    exp_t e;
    e.port = p; e.rdata = '0; e.cv = 1'b0; e.cd = 8'h00;
    if (is_con(a)) begin
      if (ws[0]) begin e.cv = 1'b1; e.cd = wd[7:0]; end
    end else if (is_hit(a)) begin
      if (ws == 4'b0000) e.rdata = ref_mem[a[AW+1:2]];
      else for (int b = 0; b < 4; b++)
        if (ws[b]) ref_mem[a[AW+1:2]][8*b +: 8] = wd[8*b +: 8];
    end
    sb.push_back(e);
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (resetn) begin
      if (m0_ready || m1_ready) begin
        exp_t e;
        rdy_cyc.push_back(cyc);
        if (m0_ready && m1_ready) chk("dual_ready", 32'd1, 32'd0);
        if (sb.size() == 0) begin
          chk("spurious_ready", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("port", 32'(m1_ready), 32'(e.port));
          chk("rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
          chk("idle_port_rdata", m1_ready ? m0_rdata : m1_rdata, 32'd0);
          chk("console_valid", 32'(console_valid), 32'(e.cv));
          chk("console_data", 32'(console_data), 32'(e.cd));
        end
      end else if (console_valid) begin
        chk("stray_console", 32'd1, 32'd0);
      end
    end
  end

  // Single request through one port, checking ACCESS-cycle SRAM drive and latency.
  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws);
    bit hit;
    int n;
    logic rdy;
    hit = is_hit(a);
    predict(p, a, wd, ws);
    @(posedge clk); #1;
    if (p == 0) begin m0_valid = 1'b1; m0_addr = a; m0_wdata = wd; m0_wstrb = ws; end
    else        begin m1_valid = 1'b1; m1_addr = a; m1_wdata = wd; m1_wstrb = ws; end
    n = 0; rdy = 1'b0;
    while (!rdy && n < 10) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (n == 1) begin
        chk("sram_en", 32'(sram_en), 32'(hit));
        chk("sram_we", 32'(sram_we), hit ? 32'(ws) : 32'd0);
        if (hit) begin
          chk("sram_addr", 32'(sram_addr), 32'(a[AW+1:2]));
          if (ws != 4'b0000) chk("sram_wdata", sram_wdata, wd);
        end
      end
      rdy = (p == 0) ? m0_ready : m1_ready;
    end
    chk("latency", 32'(n), 32'd2);
    @(posedge clk); #1;
    if (p == 0) begin m0_valid = 1'b0; m0_wstrb = '0; end
    else        begin m1_valid = 1'b0; m1_wstrb = '0; end
  endtask

  // Both ports read continuously; expect alternating grants starting at m0.
  task automatic both(input logic [31:0] a0, input logic [31:0] a1, input int n);
    int base, k;
    for (int i = 0; i < n; i++) predict(i % 2, (i % 2) ? a1 : a0, 32'd0, 4'b0000);
    base = rdy_cyc.size();
    @(posedge clk); #1;
    m0_valid = 1'b1; m0_addr = a0; m0_wstrb = 4'b0000;
    m1_valid = 1'b1; m1_addr = a1; m1_wstrb = 4'b0000;
    k = 0;
    while ((rdy_cyc.size() - base) < n && k < 100) begin
      @(negedge clk); #1; k++;
    end
    chk("ready_count", 32'(rdy_cyc.size() - base), 32'(n));
    for (int i = base + 1; i < rdy_cyc.size(); i++)
      chk("ready_gap", 32'(rdy_cyc[i] - rdy_cyc[i-1]), 32'd3);
    @(posedge clk); #1;
    m0_valid = 1'b0; m1_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[16'h100] = 32'hDEAD_BEEF; ref_mem[16'h100] = 32'hDEAD_BEEF;
    mem[16'h000] = 32'h1234_5678; ref_mem[16'h000] = 32'h1234_5678;

    // Reset values, with both masters already requesting.
    m0_valid = 1'b1; m0_addr = 32'h400;
    m1_valid = 1'b1; m1_addr = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_m0_ready", 32'(m0_ready), 32'd0);
    chk("rst_m1_ready", 32'(m1_ready), 32'd0);
    chk("rst_sram_en", 32'(sram_en), 32'd0);
    chk("rst_sram_we", 32'(sram_we), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_wdata", sram_wdata, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_console_valid", 32'(console_valid), 32'd0);
    chk("rst_console_data", 32'(console_data), 32'd0);
    resetn = 1'b1;

    // Contention from reset release: m0, m1, m0, m1.
    both(32'h400, 32'h0, 4);

    // Single read and byte write.
    issue(0, 32'h0000_0400, 32'h0, 4'b0000);
    issue(1, 32'h0000_0401, 32'h0000_AA00, 4'b0010);
    issue(0, 32'h0000_0400, 32'h0, 4'b0000);

    // Full-word write and read back across ports.
    issue(1, 32'h0000_0008, 32'hA5A5_5A5A, 4'b1111);
    issue(0, 32'h0000_0008, 32'h0, 4'b0000);

    // Out of range: write dropped (word 0 untouched), read gives 0.
    issue(0, 32'h0004_0000, 32'hCAFE_F00D, 4'b1111);
    issue(0, 32'h0004_0000, 32'h0, 4'b0000);
    issue(1, 32'h0000_0000, 32'h0, 4'b0000);

    // Console write and read of the console address.
    issue(0, 32'h1000_0000, 32'h0000_0048, 4'b0001);
    issue(1, 32'h1000_0000, 32'h0, 4'b0000);
    issue(1, 32'h0000_0000, 32'h0, 4'b0000);

    // Reset during ACCESS of an m0 read: aborted, last_grant back to 1.
    @(posedge clk); #1;
    m0_valid = 1'b1; m0_addr = 32'h400; m0_wstrb = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    chk("abort_sram_en", 32'(sram_en), 32'd1);
    resetn = 1'b0;
    #1;
    chk("abort_sram_en_rst", 32'(sram_en), 32'd0);
    chk("abort_m0_ready", 32'(m0_ready), 32'd0);
    chk("abort_sram_addr", 32'(sram_addr), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    m0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    both(32'h0, 32'h400, 2);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
